ray_aabb_hit_collector: RTL and testbench

//  Consumer-side companion to the pipelined Ray_AABB_11_52 intersection core, which accepts
//  66-bit interval operands every cycle and returns a bare hit_miss after a fixed depth.

---
 rtl/ray_aabb_pkg.sv | 28 ++
 rtl/ray_aabb_tag_fifo.sv | 63 ++++++
 rtl/ray_aabb_hit_collector.sv | 112 +++++++++++
 tb/tb_ray_aabb_hit_collector.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ray_aabb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ray_aabb_pkg
// Brief   : Shared operand format, exception codes and defaults for the ray/AABB path.
// Revision: 1.0
// ============================================================================
package ray_aabb_pkg;

  localparam int FP_W   = 66;  // 2 exception + sign + 11 exp + 52 frac
  localparam int EXP_W  = 11;
  localparam int FRAC_W = 52;

  typedef enum logic [1:0] {
    EXC_ZERO   = 2'b00,
    EXC_NORMAL = 2'b01,
    EXC_INF    = 2'b10,
    EXC_NAN    = 2'b11
  } exc_e;

  localparam int CORE_LATENCY = 12;
  localparam int TAG_W_DEF    = 8;

  function automatic exc_e fp_exc(input logic [FP_W-1:0] v);
    return exc_e'(v[FP_W-1 -: 2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ray_aabb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ray_aabb_tag_fifo
// Brief   : Show-ahead result FIFO with occupancy count and write-drop flag.
// Revision: 1.0
// ============================================================================
module ray_aabb_tag_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_wr_drop
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]   c_DEPTH = (c_PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_full;
  logic               w_wr_ok;
  logic               w_rd_ok;

  assign w_full    = (r_count == c_DEPTH);
  assign o_empty   = (r_count == '0);
  assign w_wr_ok   = i_wr_en & ~w_full;
  assign w_rd_ok   = i_rd_en & ~o_empty;
  assign o_wr_drop = i_wr_en & w_full;
  assign o_count   = r_count;
  // Head reads zero when empty so stale entries never leak to the consumer.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/ray_aabb_hit_collector.sv
`default_nettype none
// ============================================================================
// Module  : ray_aabb_hit_collector
// Brief   : Credit-gated issue, tag pipe alongside the core, and buffered hit results.
// Revision: 1.0
// ============================================================================
module ray_aabb_hit_collector
  import ray_aabb_pkg::*;
#(
  parameter int LATENCY    = CORE_LATENCY,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          in_ready,
  input  logic                          core_hit_miss,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          out_hit,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   hit_count,
  output logic                          overflow_err
);

  localparam int                   c_LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_LVL_W-1:0]   c_CREDITS = c_LVL_W'(FIFO_DEPTH);

  logic [c_LVL_W-1:0] r_outstanding;
  logic [LATENCY-1:0] r_v;
  logic [TAG_W-1:0]   r_tag [LATENCY];
  logic [31:0]        r_hit_count;
  logic               r_overflow_err;

  logic               w_issue;
  logic               w_pop;
  logic               w_cap;
  logic [TAG_W:0]     w_cap_data;
  logic [TAG_W:0]     w_rd_data;
  logic               w_empty;
  logic               w_wr_drop;

  // Credits cover both in-flight rays and buffered results, so a capture always finds room.
  assign in_ready   = (r_outstanding < c_CREDITS);
  assign w_issue    = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;
  assign w_cap      = r_v[LATENCY-1];
  assign w_cap_data = {r_tag[LATENCY-1], core_hit_miss};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_issue, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v <= '0;
      for (int i = 0; i < LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_v[0]   <= w_issue;
      r_tag[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        r_v[i]   <= r_v[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  ray_aabb_tag_fifo #(
    .DATA_W (TAG_W + 1),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_cap),
    .i_wr_data (w_cap_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_empty   (w_empty),
    .o_count   (fifo_level),
    .o_wr_drop (w_wr_drop)
  );

  assign out_valid = ~w_empty;
  assign out_tag   = w_rd_data[TAG_W:1];
  assign out_hit   = w_rd_data[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_count    <= '0;
      r_overflow_err <= 1'b0;
    end else begin
      if (w_pop && out_hit && (r_hit_count != '1)) r_hit_count <= r_hit_count + 32'd1;
      if (w_wr_drop) r_overflow_err <= 1'b1;
    end
  end

  assign hit_count    = r_hit_count;
  assign overflow_err = r_overflow_err;

endmodule
`default_nettype wire

// File: tb/tb_ray_aabb_hit_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_ray_aabb_hit_collector
// Brief   : Randomised and directed bench with a queue-based model of the collector.
// Revision: 1.0
// ============================================================================
module tb_ray_aabb_hit_collector;

  localparam int L = 12;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_tag = '0;
  logic       in_ready;
  logic       core_hit_miss = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_tag;
  logic       out_hit;
  logic [4:0] fifo_level;
  logic [31:0] hit_count;
  logic       overflow_err;

  ray_aabb_hit_collector #(.LATENCY(L), .TAG_W(8), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_tag(in_tag), .in_ready(in_ready),
    .core_hit_miss(core_hit_miss), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_hit(out_hit), .fifo_level(fifo_level),
    .hit_count(hit_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] tag; bit hit; int cap_edge; } fl_t;
  typedef struct { logic [7:0] tag; bit hit; } res_t;

  fl_t    inflight[$];
  res_t   mfifo[$];
  res_t   dut_pop[$];
  bit     sched[int];
  longint m_hits;
  bit     m_ovf;
  int     cyc;
  bit     next_hit;
  bit     idle_one;
  int     checks;
  int     errors;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, (inflight.size() + mfifo.size()) < D);
    chk("out_valid", out_valid, mfifo.size() > 0);
    chk("out_tag", out_tag, mfifo.size() > 0 ? mfifo[0].tag : 8'h00);
    chk("out_hit", out_hit, mfifo.size() > 0 ? mfifo[0].hit : 1'b0);
    chk("fifo_level", fifo_level, mfifo.size());
    chk("hit_count", hit_count, m_hits);
    chk("overflow_err", overflow_err, m_ovf);
  endtask

  task automatic model_reset();
    inflight.delete();
    mfifo.delete();
    m_hits = 0;
    m_ovf  = 0;
  endtask

  // One clock: drive the core, advance the model across the coming edge, then compare.
  task automatic tick();
    int   e;
    bit   issue, pop, full_before;
    res_t r;
    fl_t  f;
    e = cyc + 1;
    if (sched.exists(cyc)) core_hit_miss = sched[cyc];
    else core_hit_miss = idle_one ? 1'b1 : 1'($urandom % 2);
    if (out_valid && out_ready) dut_pop.push_back('{out_tag, out_hit});
    issue       = in_valid && ((inflight.size() + mfifo.size()) < D);
    pop         = out_ready && (mfifo.size() > 0);
    full_before = (mfifo.size() == D);
    if (pop) begin
      r = mfifo.pop_front();
      if (r.hit && m_hits != 64'hFFFF_FFFF) m_hits++;
    end
    if (inflight.size() > 0 && inflight[0].cap_edge == e) begin
      f = inflight.pop_front();
      if (full_before) m_ovf = 1;
      else mfifo.push_back('{f.tag, f.hit});
    end
    if (issue) begin
      sched[e + L - 1] = next_hit;
      inflight.push_back('{in_tag, next_hit, e + L});
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, i, dut_iss, peak, k;
    bit saw;
    logic [31:0] hc0;
    checks = 0; errors = 0; cyc = 0; idle_one = 0; next_hit = 0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_fifo_level", fifo_level, 5'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_overflow", overflow_err, 1'b0);
    chk("rst_out_tag", out_tag, 8'h00);
    rst = 1'b1;

    // Single ray
    in_valid = 1; in_tag = 8'h05; next_hit = 1;
    n = cyc + 1;
    tick();
    in_valid = 0;
    k = 0;
    while (!out_valid && k < 30) begin tick(); k++; end
    chk("single_latency", cyc - n, L);
    chk("single_tag", out_tag, 8'h05);
    chk("single_hit", out_hit, 1'b1);
    out_ready = 1; tick(); out_ready = 0;
    chk("single_hit_count", hit_count, 32'd1);

    // Backpressure
    i = 0; dut_iss = 0; peak = 0;
    for (int c = 0; c < 60; c++) begin
      in_valid = (i < 20); in_tag = 8'(i); next_hit = 1'($urandom % 2);
      if (in_valid && in_ready) begin dut_iss++; i++; end
      if (int'(fifo_level) > peak) peak = fifo_level;
      tick();
    end
    in_valid = 0;
    if (int'(fifo_level) > peak) peak = fifo_level;
    chk("bp_issues", dut_iss, 16);
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_peak_level", peak, 16);
    chk("bp_overflow", overflow_err, 1'b0);
    dut_pop.delete();
    out_ready = 1;
    repeat (20) tick();
    out_ready = 0;
    chk("bp_pop_count", dut_pop.size(), 16);
    for (int j = 0; j < 16 && j < dut_pop.size(); j++) chk("bp_order", dut_pop[j].tag, 8'(j));

    // Simultaneous issue and pop around the credit limit
    in_valid = 1;
    for (int j = 0; j < 15; j++) begin in_tag = 8'(8'h20 + j); next_hit = 1'($urandom % 2); tick(); end
    in_valid = 0;
    repeat (L + 2) tick();
    chk("sim_level15", fifo_level, 5'd15);
    in_valid = 1; out_ready = 1; in_tag = 8'h30; tick();
    chk("sim_ready_at15", in_ready, 1'b1);
    out_ready = 0; in_tag = 8'h31; tick();
    chk("sim_ready_at16", in_ready, 1'b0);
    out_ready = 1; in_tag = 8'h32;
    chk("sim_ready_pop_cycle", in_ready, 1'b0);
    tick();
    chk("sim_ready_after_pop", in_ready, 1'b1);
    in_valid = 0;
    repeat (40) tick();

    // Mixed hit/miss
    dut_pop.delete();
    hc0 = hit_count;
    in_valid = 1;
    for (int j = 0; j < 8; j++) begin in_tag = 8'(8'h40 + j); next_hit = (j % 2 == 0); tick(); end
    in_valid = 0;
    repeat (L + 4) tick();
    chk("mix_pops", dut_pop.size(), 8);
    for (int j = 0; j < 8 && j < dut_pop.size(); j++) chk("mix_hit_seq", dut_pop[j].hit, (j % 2 == 0));
    chk("mix_hit_delta", hit_count - hc0, 32'd4);
    out_ready = 0;

    // Flush with rays in flight
    idle_one = 1;
    in_valid = 1;
    for (int j = 0; j < 3; j++) begin in_tag = 8'(8'h60 + j); next_hit = 1; tick(); end
    in_valid = 0;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs();
    #1;
    rst = 1'b1;
    saw = 0;
    repeat (2 * L) begin tick(); if (out_valid) saw = 1; end
    chk("flush_no_valid", saw, 1'b0);
    chk("flush_level", fifo_level, 5'd0);
    idle_one = 0;

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_tag    = 8'($urandom);
      next_hit  = 1'($urandom % 2);
      tick();
    end
    in_valid = 0; out_ready = 1;
    repeat (40) tick();
    chk("drain_level", fifo_level, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
